// File: rtl/dram_stream_packer.sv
// dram_stream_packer: packs IN_W-bit DRAM beats MSB-first into OUT_W-bit
// memory words and writes them round-robin across NUM_MEM banks.
//
// state | meaning
// IDLE  | waiting for start_i; input not accepted
// FILL  | accepting beats, emitting a word whenever OUT_W bits are held
// FLUSH | writing the zero-padded leftover bits after the last beat
// DONE  | closing the transfer with a one-cycle done_o pulse
module dram_stream_packer #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 163,
    parameter int NUM_MEM = 4,
    parameter int ADDR_W  = 10,
    parameter int SEL_W   = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
    input  logic              clk_i,
    input  logic              dram_pack_rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] words_per_mem_i,
    input  logic [IN_W-1:0]   data_in_i,
    input  logic              data_valid_i,
    input  logic              data_last_i,
    output logic              data_ready_o,
    output logic [OUT_W-1:0]  data_out_o,
    output logic              memory_write_enable_o,
    output logic [ADDR_W-1:0] memory_addr_o,
    output logic [SEL_W-1:0]  memory_sel_o,
    output logic              done_o
);

    localparam int ACC_W = OUT_W + IN_W - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);

    generate
        if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
            $error("dram_stream_packer: IN_W must satisfy 1 <= IN_W <= OUT_W");
        end
        if (NUM_MEM < 1) begin : g_bad_mem
            $error("dram_stream_packer: NUM_MEM must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // Held bits are left-aligned in acc_q; everything below cnt_q is zero.
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  wpm_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [SEL_W-1:0]   wr_sel_q;
    logic               done_q;

    logic               accept;
    logic [ACC_W-1:0]   beat_ext;
    logic [ACC_W-1:0]   acc_app;
    logic [CNT_W-1:0]   cnt_app;
    logic               fill_emit;
    logic [ACC_W-1:0]   acc_left;
    logic [CNT_W-1:0]   cnt_left;
    logic               emit;
    logic [OUT_W-1:0]   emit_word;
    logic               done_d;
    logic               addr_wrap;
    logic [SEL_W-1:0]   sel_next;

    // Append datapath: place the incoming beat just below the held bits and
    // split off a full word when enough bits are present.
    always_comb begin
        accept    = (state_q == S_FILL) && data_valid_i;
        beat_ext  = ACC_W'(data_in_i) << (ACC_W - IN_W);
        acc_app   = acc_q | (beat_ext >> cnt_q);
        cnt_app   = cnt_q + CNT_W'(IN_W);
        fill_emit = accept && (cnt_app >= CNT_W'(OUT_W));
        acc_left  = fill_emit ? (acc_app << OUT_W) : acc_app;
        cnt_left  = fill_emit ? (cnt_app - CNT_W'(OUT_W)) : cnt_app;
        addr_wrap = (wr_addr_q == (wpm_q - ADDR_W'(1)));
        sel_next  = (wr_sel_q == SEL_W'(NUM_MEM - 1)) ? '0 : (wr_sel_q + SEL_W'(1));
    end

    // State register.
    always_ff @(posedge clk_i or posedge dram_pack_rst_i) begin
        if (dram_pack_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake and word-emit decode.
    always_comb begin
        state_d      = state_q;
        data_ready_o = 1'b0;
        emit         = 1'b0;
        emit_word    = '0;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                data_ready_o = 1'b1;
                if (fill_emit) begin
                    emit      = 1'b1;
                    emit_word = acc_app[ACC_W-1 -: OUT_W];
                end
                if (accept && data_last_i) begin
                    if (cnt_left != '0) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                emit      = 1'b1;
                emit_word = acc_q[ACC_W-1 -: OUT_W];
                state_d   = S_DONE;
            end
            S_DONE: begin
                // Without a flush, done was already raised alongside the final
                // write; only the flush path pulses it from here.
                done_d  = !done_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Accumulator, address counters and registered memory-write outputs.
    always_ff @(posedge clk_i or posedge dram_pack_rst_i) begin
        if (dram_pack_rst_i) begin
            acc_q                 <= '0;
            cnt_q                 <= '0;
            wpm_q                 <= '0;
            wr_addr_q             <= '0;
            wr_sel_q              <= '0;
            done_q                <= 1'b0;
            data_out_o            <= '0;
            memory_write_enable_o <= 1'b0;
            memory_addr_o         <= '0;
            memory_sel_o          <= '0;
        end else begin
            memory_write_enable_o <= emit;
            done_q                <= done_d;
            if (emit) begin
                data_out_o    <= emit_word;
                memory_addr_o <= wr_addr_q;
                memory_sel_o  <= wr_sel_q;
                if (addr_wrap) begin
                    wr_addr_q <= '0;
                    wr_sel_q  <= sel_next;
                end else begin
                    wr_addr_q <= wr_addr_q + ADDR_W'(1);
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        wr_addr_q <= '0;
                        wr_sel_q  <= '0;
                        wpm_q     <= words_per_mem_i;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        acc_q <= acc_left;
                        cnt_q <= cnt_left;
                    end
                end
                S_FLUSH: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign done_o = done_q;

endmodule
